// File: rtl/buscaminas_pkg.sv
// Shared definitions for the Buscaminas board logic: board size, FSM states
// and the (x, y) -> linear cell index mapping used by every board consumer.
package buscaminas_pkg;

    localparam int BOARD_N = 8;
    localparam int COORD_W = $clog2(BOARD_N);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SWEEP,
        EVAL,
        LOST,
        WON
    } state_t;

    // Row-major linear index of a cell on an n x n board.
    function automatic int cell_idx(input int x, input int y, input int n = BOARD_N);
        return y * n + x;
    endfunction

endpackage

// File: rtl/neighbor_counter.sv
// Combinational count of mines among the in-board 8-neighbours of one cell.
// The cell itself is never counted and there is no wrap-around at the edges.
module neighbor_counter #(
    parameter int N  = 8,
    parameter int IW = $clog2(N * N)
) (
    input  logic [N*N-1:0] i_mines,
    input  logic [IW-1:0]  i_idx,
    output logic [3:0]     o_count
);

    // Walk the 3x3 window around the cell, skipping the centre and off-board positions.
    always_comb begin
        int x;
        int y;
        int nx;
        int ny;
        int acc;
        acc = 0;
        nx  = 0;
        ny  = 0;
        x   = int'(i_idx) % N;
        y   = int'(i_idx) / N;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = x + dx;
                ny = y + dy;
                if (!(dx == 0 && dy == 0) && nx >= 0 && nx < N && ny >= 0 && ny < N) begin
                    acc = acc + int'(i_mines[IW'(ny * N + nx)]);
                end
            end
        end
        o_count = 4'(acc);
    end

endmodule

// File: rtl/cell_reveal_engine.sv
// Reveal engine for the Buscaminas board: reveals the cursor cell on request,
// floods zero-count regions with repeated row-major sweeps (one cell per
// cycle), and tracks the sticky lost / won outcome of the current game.
module cell_reveal_engine
    import buscaminas_pkg::*;
#(
    parameter int N = BOARD_N,
    parameter int W = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           new_game,
    input  logic [N*N-1:0] mine_map_in,
    input  logic [W-1:0]   cursor_x,
    input  logic [W-1:0]   cursor_y,
    input  logic           reveal_req,
    output logic           busy,
    output logic           done,
    output logic [N*N-1:0] revealed_map,
    output logic           game_over,
    output logic           game_won,
    output logic [3:0]     cur_count
);

    localparam int NN = N * N;
    localparam int IW = $clog2(NN);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NN-1:0]   r_mines;
    logic [NN-1:0]   w_mines_nxt;
    logic [NN-1:0]   r_revealed;
    logic [NN-1:0]   w_rev_nxt;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_nxt;
    logic            r_changed;
    logic            w_changed_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            r_over;
    logic            w_over_nxt;
    logic            r_won;
    logic            w_won_nxt;
    logic [3:0]      r_cur_count;

    logic [IW-1:0]   w_cur_idx;
    logic [3:0]      w_scan_cnt;
    logic [3:0]      w_cur_cnt;
    logic [NN-1:0]   w_zero;
    logic [NN-1:0]   w_seed;
    logic            w_sweep_hit;
    logic            w_all_safe;

    // True when any in-board 8-neighbour of cell idx has its bit set in map.
    function automatic logic any_nbr(input logic [NN-1:0] map, input int idx);
        logic hit;
        int   x;
        int   y;
        int   nx;
        int   ny;
        hit = 1'b0;
        x   = idx % N;
        y   = idx / N;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = x + dx;
                ny = y + dy;
                if (!(dx == 0 && dy == 0) && nx >= 0 && nx < N && ny >= 0 && ny < N) begin
                    hit = hit | map[IW'(ny * N + nx)];
                end
            end
        end
        return hit;
    endfunction

    assign w_cur_idx = IW'(cell_idx(int'(cursor_x), int'(cursor_y), N));

    neighbor_counter #(.N(N)) u_scan_cnt (
        .i_mines (r_mines),
        .i_idx   (r_idx),
        .o_count (w_scan_cnt)
    );

    neighbor_counter #(.N(N)) u_cursor_cnt (
        .i_mines (r_mines),
        .i_idx   (w_cur_idx),
        .o_count (w_cur_cnt)
    );

    // Zero-count map: cells with no adjacent mine, derived from the latched mine layout.
    always_comb begin
        w_zero = '0;
        for (int i = 0; i < NN; i++) begin
            w_zero[IW'(i)] = ~any_nbr(r_mines, i);
        end
    end

    // A revealed safe zero-count cell opens all its neighbours during a sweep.
    assign w_seed      = r_revealed & w_zero & ~r_mines;
    assign w_sweep_hit = ~r_revealed[r_idx] & ~r_mines[r_idx] & any_nbr(w_seed, int'(r_idx));
    assign w_all_safe  = ($countones(r_revealed) == (NN - $countones(r_mines)));

    // Next-state and next-value logic for the reveal / flood / evaluate sequence.
    always_comb begin
        w_state_nxt   = r_state;
        w_mines_nxt   = r_mines;
        w_rev_nxt     = r_revealed;
        w_idx_nxt     = r_idx;
        w_changed_nxt = r_changed;
        w_done_nxt    = 1'b0;
        w_over_nxt    = r_over;
        w_won_nxt     = r_won;
        if (new_game) begin
            w_state_nxt   = IDLE;
            w_mines_nxt   = mine_map_in;
            w_rev_nxt     = '0;
            w_idx_nxt     = '0;
            w_changed_nxt = 1'b0;
            w_over_nxt    = 1'b0;
            w_won_nxt     = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (reveal_req && !r_over && !r_won) begin
                        w_idx_nxt   = w_cur_idx;
                        w_state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    if (r_revealed[r_idx]) begin
                        w_state_nxt = EVAL;
                    end else if (r_mines[r_idx]) begin
                        w_rev_nxt[r_idx] = 1'b1;
                        w_over_nxt       = 1'b1;
                        w_done_nxt       = 1'b1;
                        w_state_nxt      = LOST;
                    end else begin
                        w_rev_nxt[r_idx] = 1'b1;
                        if (w_scan_cnt == 4'd0) begin
                            w_idx_nxt     = '0;
                            w_changed_nxt = 1'b0;
                            w_state_nxt   = SWEEP;
                        end else begin
                            w_state_nxt = EVAL;
                        end
                    end
                end
                SWEEP: begin
                    if (w_sweep_hit) begin
                        w_rev_nxt[r_idx] = 1'b1;
                        w_changed_nxt    = 1'b1;
                    end
                    if (r_idx == IW'(NN - 1)) begin
                        if (r_changed || w_sweep_hit) begin
                            w_idx_nxt     = '0;
                            w_changed_nxt = 1'b0;
                        end else begin
                            w_state_nxt = EVAL;
                        end
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end
                EVAL: begin
                    w_done_nxt = 1'b1;
                    if (w_all_safe) begin
                        w_won_nxt   = 1'b1;
                        w_state_nxt = WON;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                LOST: w_state_nxt = LOST;
                WON:  w_state_nxt = WON;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Board maps, scan position, flags and the registered cursor count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mines     <= '0;
            r_revealed  <= '0;
            r_idx       <= '0;
            r_changed   <= 1'b0;
            r_done      <= 1'b0;
            r_over      <= 1'b0;
            r_won       <= 1'b0;
            r_cur_count <= 4'd0;
        end else begin
            r_mines     <= w_mines_nxt;
            r_revealed  <= w_rev_nxt;
            r_idx       <= w_idx_nxt;
            r_changed   <= w_changed_nxt;
            r_done      <= w_done_nxt;
            r_over      <= w_over_nxt;
            r_won       <= w_won_nxt;
            r_cur_count <= w_cur_cnt;
        end
    end

    assign busy         = (r_state == CHECK) || (r_state == SWEEP) || (r_state == EVAL);
    assign done         = r_done;
    assign revealed_map = r_revealed;
    assign game_over    = r_over;
    assign game_won     = r_won;
    assign cur_count    = r_cur_count;

endmodule

// File: tb/tb_cell_reveal_engine.sv
// Scoreboard bench for cell_reveal_engine: each accepted reveal pushes the
// reference model's expected board, flags and latency; a monitor pops and
// compares whenever done pulses.
module tb_cell_reveal_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_game = 1'b0;
    logic        reveal_req = 1'b0;
    logic [63:0] mine_map_in = '0;
    logic [2:0]  cursor_x = '0;
    logic [2:0]  cursor_y = '0;
    logic        busy;
    logic        done;
    logic        game_over;
    logic        game_won;
    logic [63:0] revealed_map;
    logic [3:0]  cur_count;

    cell_reveal_engine #(.N(8), .W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .new_game     (new_game),
        .mine_map_in  (mine_map_in),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .reveal_req   (reveal_req),
        .busy         (busy),
        .done         (done),
        .revealed_map (revealed_map),
        .game_over    (game_over),
        .game_won     (game_won),
        .cur_count    (cur_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] map;
        logic        over;
        logic        won;
        int          lat;
        int          issue;
    } exp_t;

    exp_t sb[$];

    // Reference game state.
    bit [63:0] m_mines;
    bit [63:0] m_rev;
    bit        m_over;
    bit        m_won;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int ref_count(input bit [63:0] mines, input int i);
        int c;
        int x;
        int y;
        c = 0;
        x = i % 8;
        y = i / 8;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < 8 && y + dy >= 0 && y + dy < 8)
                    c += int'(mines[6'((y + dy) * 8 + x + dx)]);
        return c;
    endfunction

    // Cell i touches a shown safe cell that has no adjacent mines.
    function automatic bit has_open_nbr(input int i);
        int x;
        int y;
        int j;
        bit r;
        r = 0;
        x = i % 8;
        y = i / 8;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < 8 && y + dy >= 0 && y + dy < 8) begin
                    j = (y + dy) * 8 + x + dx;
                    if (m_rev[6'(j)] && !m_mines[6'(j)] && ref_count(m_mines, j) == 0) r = 1;
                end
        return r;
    endfunction

    task automatic model_reveal(input int i, output exp_t e);
        int k;
        bit changed;
        e.lat = 3;
        if (m_rev[6'(i)]) begin
            e.lat = 3;
        end else if (m_mines[6'(i)]) begin
            m_rev[6'(i)] = 1;
            m_over = 1;
            e.lat = 2;
        end else begin
            m_rev[6'(i)] = 1;
            if (ref_count(m_mines, i) == 0) begin
                k = 0;
                do begin
                    changed = 0;
                    k++;
                    for (int c = 0; c < 64; c++)
                        if (!m_rev[6'(c)] && !m_mines[6'(c)] && has_open_nbr(c)) begin
                            m_rev[6'(c)] = 1;
                            changed = 1;
                        end
                end while (changed);
                e.lat = 3 + 64 * k;
            end
        end
        if (!m_over && $countones(m_rev) == 64 - $countones(m_mines)) m_won = 1;
        e.map  = m_rev;
        e.over = m_over;
        e.won  = m_won;
        e.issue = 0;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_map", revealed_map, e.map);
                chk("done_over", 64'(game_over), 64'(e.over));
                chk("done_won", 64'(game_won), 64'(e.won));
                chk("done_latency", 64'(cyc - e.issue), 64'(e.lat));
                chk("done_busy", 64'(busy), 64'(0));
            end
        end
    end

    task automatic wait_sb(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d outstanding after %0d cycles expected 0", sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic start_game(input logic [63:0] m);
        @(negedge clk);
        mine_map_in = m;
        new_game = 1'b1;
        m_mines = m;
        m_rev = '0;
        m_over = 0;
        m_won = 0;
        sb.delete();
        @(negedge clk);
        new_game = 1'b0;
    endtask

    task automatic do_reveal(input int x, input int y, input bit wait_done);
        exp_t e;
        bit ign;
        @(negedge clk);
        cursor_x = 3'(x);
        cursor_y = 3'(y);
        reveal_req = 1'b1;
        ign = m_over || m_won;
        if (!ign) begin
            model_reveal(y * 8 + x, e);
            e.issue = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        reveal_req = 1'b0;
        if (ign) begin
            repeat (4) @(negedge clk);
            chk("ignored_map", revealed_map, m_rev);
            chk("ignored_busy", 64'(busy), 64'(0));
        end else if (wait_done) begin
            wait_sb(5000);
        end
    endtask

    task automatic check_count(input int x, input int y, input int expv, input string name);
        @(negedge clk);
        cursor_x = 3'(x);
        cursor_y = 3'(y);
        @(negedge clk);
        chk(name, 64'(cur_count), 64'(expv));
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: got no finish expected finish before 1.5ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] m;
        int dens_tab[6];
        dens_tab = '{0, 8, 15, 25, 50, 100};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_map", revealed_map, 64'h0);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_over", 64'(game_over), 64'(0));
        chk("reset_won", 64'(game_won), 64'(0));
        chk("reset_count", 64'(cur_count), 64'(0));

        // Flood from the far corner around mines 0 and 9.
        start_game((64'd1 << 0) | (64'd1 << 9));
        do_reveal(7, 7, 1);
        chk("flood_popcount", 64'($countones(revealed_map)), 64'(60));
        chk("flood_map", revealed_map, ~((64'd1 << 0) | (64'd1 << 1) | (64'd1 << 8) | (64'd1 << 9)));
        chk("flood_won", 64'(game_won), 64'(0));
        do_reveal(1, 0, 1);
        do_reveal(0, 1, 1);
        chk("win_flag", 64'(game_won), 64'(1));
        chk("win_popcount", 64'($countones(revealed_map)), 64'(62));
        do_reveal(3, 3, 1);

        // Single mine hit.
        start_game(64'd1 << 27);
        do_reveal(3, 3, 1);
        chk("lost_flag", 64'(game_over), 64'(1));
        chk("lost_map", revealed_map, 64'd1 << 27);
        do_reveal(0, 0, 1);

        // Already-revealed cells, non-zero and zero.
        start_game((64'd1 << 0) | (64'd1 << 9));
        do_reveal(1, 0, 1);
        do_reveal(1, 0, 1);
        do_reveal(7, 7, 1);
        do_reveal(6, 6, 1);

        // Abort a sweep with new_game.
        start_game(64'h0);
        do_reveal(7, 7, 0);
        repeat (10) @(negedge clk);
        chk("sweep_busy", 64'(busy), 64'(1));
        start_game(64'd1 << 5);
        chk("abort_map", revealed_map, 64'h0);
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        repeat (80) @(negedge clk);
        check_count(4, 0, 1, "abort_new_mines");

        // Cursor neighbour counts.
        start_game((64'd1 << 1) | (64'd1 << 8) | (64'd1 << 9));
        check_count(0, 0, 3, "count_corner00");
        start_game((64'd1 << 54) | (64'd1 << 55) | (64'd1 << 62) | (64'd1 << 63));
        check_count(7, 7, 3, "count_corner77");
        start_game(64'h0);
        check_count(3, 4, 0, "count_empty");

        // Randomized games from mine-free to all-mine boards.
        for (int g = 0; g < 6; g++) begin
            m = '0;
            for (int i = 0; i < 64; i++)
                m[6'(i)] = ($urandom_range(0, 99) < dens_tab[g]);
            start_game(m);
            for (int r = 0; r < 3; r++) begin
                int rx;
                int ry;
                rx = int'($urandom_range(0, 7));
                ry = int'($urandom_range(0, 7));
                check_count(rx, ry, ref_count(m, ry * 8 + rx), "count_random");
            end
            for (int r = 0; r < 10; r++)
                do_reveal(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
